// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the serial nibble add/subtract unit.
//   state_t : controller FSM encoding (IDLE, RUN, DONE)
//   NIB_W   : width of the ripple-carry slice that is stepped across operands
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_slice.sv
// ----------------------------------------------------------------------------
// nibble_add_slice
// Combinational 4-bit ripple-carry adder slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : sum nibble
//   c3   : carry into bit 3 (used for signed overflow on the top nibble)
//   co   : carry out of bit 3
// ----------------------------------------------------------------------------
module nibble_add_slice
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             c3,
    output logic             co
);

    // carry[k] is the carry into bit k; carry[NIB_W] is the carry out.
    logic [NIB_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
            assign s[gi]        = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c3 = carry[NIB_W-1];
    assign co = carry[NIB_W];

endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_nibble_adder_ctrl
// Multi-cycle WIDTH-bit add/subtract built from one 4-bit ripple slice that
// is applied one nibble per clock, least-significant nibble first.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_valid/ready   : operand handshake (a, b, sub sampled on acceptance)
//   a, b, sub           : operands; sub=1 computes a - b
//   res_valid/ready     : result handshake
//   sum, cout, ovf      : result, carry out of MSB (no-borrow for subtract),
//                         signed overflow
//   busy                : high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module serial_nibble_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("serial_nibble_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg, sum_reg, sum_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg, cout_reg, ovf_reg;

    logic [NIB_W-1:0]   a_nibs [NIB];
    logic [NIB_W-1:0]   b_nibs [NIB];
    logic [NIB_W-1:0]   slice_s;
    logic               slice_c3, slice_co;
    logic               accept, run_last;

    assign accept   = (state_reg == IDLE) && start_valid;
    assign run_last = (state_reg == RUN) && (idx_reg == IDX_LAST);

    // Nibble views of the operands, and the sum register with the current
    // nibble replaced by the slice output.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
            assign a_nibs[gi] = a_reg[gi*NIB_W +: NIB_W];
            assign b_nibs[gi] = b_reg[gi*NIB_W +: NIB_W];
            assign sum_next[gi*NIB_W +: NIB_W] =
                (idx_reg == GI_IDX) ? slice_s : sum_reg[gi*NIB_W +: NIB_W];
        end
    endgenerate

    nibble_add_slice u_slice (
        .a   (a_nibs[idx_reg]),
        .b   (b_nibs[idx_reg]),
        .cin (carry_reg),
        .s   (slice_s),
        .c3  (slice_c3),
        .co  (slice_co)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (idx_reg == IDX_LAST) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        start_ready = (state_reg == IDLE);
        res_valid   = (state_reg == DONE);
        busy        = (state_reg != IDLE);
    end

    // Datapath: operands, index, inter-nibble carry and result registers.
    // Subtraction is a + ~b + 1, so b is inverted on load and the carry
    // register is seeded with sub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            idx_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (state_reg == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= slice_co;
            if (run_last) begin
                idx_reg  <= '0;
                cout_reg <= slice_co;
                ovf_reg  <= slice_c3 ^ slice_co;
            end else begin
                idx_reg  <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_nibble_adder_ctrl
// Scoreboard bench: stimulus pushes expected results into per-DUT queues,
// monitors pop and compare on every result handshake. A 16-bit instance takes
// hand-computed vectors, backpressure and mid-operation reset; an 8-bit
// instance takes 256 back-to-back random operations against a reference model.
// ----------------------------------------------------------------------------
module tb_serial_nibble_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        sv16, sr16, sub16, rv16, rr16, cout16, ovf16, busy16;
    logic [15:0] a16, b16, sum16;
    logic        sv8, sr8, sub8, rv8, rr8, cout8, ovf8, busy8;
    logic [7:0]  a8, b8, sum8;

    serial_nibble_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .start_valid(sv16), .start_ready(sr16),
        .a(a16), .b(b16), .sub(sub16),
        .res_valid(rv16), .res_ready(rr16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
    );

    serial_nibble_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .sub(sub8),
        .res_valid(rv8), .res_ready(rr8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb16[$];
    exp_t sb8[$];
    exp_t e16, e8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitors: compare on each result handshake.
    always @(negedge clk) begin
        if (!rst && rv16 && rr16) begin
            if (sb16.size() == 0) begin
                fail_now("w16_unexpected_result");
            end else begin
                e16 = sb16.pop_front();
                chk({e16.name, "_sum"},  32'(sum16),  32'(e16.sum));
                chk({e16.name, "_cout"}, 32'(cout16), 32'(e16.cout));
                chk({e16.name, "_ovf"},  32'(ovf16),  32'(e16.ovf));
                $display("w16 %s sum=%h cout=%b ovf=%b", e16.name, sum16, cout16, ovf16);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rv8 && rr8) begin
            if (sb8.size() == 0) begin
                fail_now("w8_unexpected_result");
            end else begin
                e8 = sb8.pop_front();
                chk({e8.name, "_sum"},  32'(sum8),  32'(e8.sum));
                chk({e8.name, "_cout"}, 32'(cout8), 32'(e8.cout));
                chk({e8.name, "_ovf"},  32'(ovf8),  32'(e8.ovf));
                $display("w8 %s sum=%h cout=%b ovf=%b", e8.name, sum8, cout8, ovf8);
            end
        end
    end

    // Issue one 16-bit operation; returns one #1 after the acceptance edge.
    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic s,
                           input logic [15:0] es, input logic ec, input logic eo,
                           input string nm, output int acc);
        int n;
        exp_t e;
        n = 0;
        acc = cyc;
        while (!sr16) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                fail_now({nm, "_start_ready"});
                return;
            end
        end
        a16 = av; b16 = bv; sub16 = s; sv16 = 1'b1;
        acc = cyc;
        e.sum = es; e.cout = ec; e.ovf = eo; e.name = nm;
        sb16.push_back(e);
        @(posedge clk); #1;
        sv16 = 1'b0;
    endtask

    // Wait for res_valid and check latency from the acceptance cycle.
    task automatic wait_res16(input int acc, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!rv16) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                fail_now({nm, "_res_valid"});
                return;
            end
        end
        chk({nm, "_latency"}, 32'(cyc - acc), 32'd5);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, prev_acc, n;
        logic [7:0] av, bv;
        logic s;
        int sa, sbi, r;
        exp_t e;

        rst = 1'b1;
        sv16 = 0; a16 = 0; b16 = 0; sub16 = 0; rr16 = 1;
        sv8 = 0;  a8 = 0;  b8 = 0;  sub8 = 0;  rr8 = 1;

        // Reset state
        @(negedge clk);
        chk("rst_start_ready", 32'(sr16), 32'd1);
        chk("rst_res_valid",   32'(rv16), 32'd0);
        chk("rst_busy",        32'(busy16), 32'd0);
        chk("rst_sum",         32'(sum16), 32'd0);
        chk("rst_cout",        32'(cout16), 32'd0);
        chk("rst_ovf",         32'(ovf16), 32'd0);
        chk("rst8_start_ready", 32'(sr8), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        issue16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "add_1234_0fff", acc);
        chk("busy_in_run", 32'(busy16), 32'd1);
        wait_res16(acc, "add_1234_0fff");
        issue16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_0001", acc);
        wait_res16(acc, "add_ffff_0001");
        issue16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_0001", acc);
        wait_res16(acc, "add_7fff_0001");
        issue16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_0005_0007", acc);
        wait_res16(acc, "sub_0005_0007");
        issue16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_0001", acc);
        wait_res16(acc, "sub_8000_0001");

        // Backpressure: result held in DONE for 10 cycles
        rr16 = 1'b0;
        issue16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "bp_1234_0fff", acc);
        wait_res16(acc, "bp_1234_0fff");
        for (int i = 0; i < 10; i++) begin
            sv16  = ~sv16;
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            sub16 = ~sub16;
            @(negedge clk);
            chk("bp_res_valid",   32'(rv16),   32'd1);
            chk("bp_sum",         32'(sum16),  32'h2233);
            chk("bp_cout",        32'(cout16), 32'd0);
            chk("bp_ovf",         32'(ovf16),  32'd0);
            chk("bp_start_ready", 32'(sr16),   32'd0);
            @(posedge clk); #1;
        end
        sv16 = 1'b0;
        rr16 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_start_ready", 32'(sr16), 32'd1);
        chk("bp_release_res_valid",   32'(rv16), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_no_accept_busy", 32'(busy16), 32'd0);

        // Reset in the 2nd RUN cycle
        issue16(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "rst_mid", acc);
        @(posedge clk); #1;
        rst = 1'b1;
        sb16.delete();
        @(negedge clk);
        chk("rstmid_sum",         32'(sum16),  32'd0);
        chk("rstmid_cout",        32'(cout16), 32'd0);
        chk("rstmid_ovf",         32'(ovf16),  32'd0);
        chk("rstmid_res_valid",   32'(rv16),   32'd0);
        chk("rstmid_busy",        32'(busy16), 32'd0);
        chk("rstmid_start_ready", 32'(sr16),   32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue16(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "post_rst_add", acc);
        wait_res16(acc, "post_rst_add");

        // WIDTH=8: 256 back-to-back random operations
        prev_acc = 0;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!sr8 && n <= 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n > 50) begin
                fail_now("w8_start_ready");
                break;
            end
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            s  = 1'($urandom_range(0, 1));
            sa  = $signed({{24{av[7]}}, av});
            sbi = $signed({{24{bv[7]}}, bv});
            r   = s ? (sa - sbi) : (sa + sbi);
            e.sum  = {8'h00, (s ? (av - bv) : (av + bv))};
            e.cout = s ? (av >= bv) : ((32'(av) + 32'(bv)) > 32'd255);
            e.ovf  = (r > 127) || (r < -128);
            e.name = $sformatf("w8_%0d", i);
            sb8.push_back(e);
            a8 = av; b8 = bv; sub8 = s; sv8 = 1'b1;
            acc = cyc;
            if (i > 0) chk("w8_issue_interval", 32'(acc - prev_acc), 32'd4);
            prev_acc = acc;
            @(posedge clk); #1;
            sv8 = 1'b0;
        end

        repeat (10) @(posedge clk);
        #1;
        chk("w8_queue_drained",  32'(sb8.size()),  32'd0);
        chk("w16_queue_drained", 32'(sb16.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
